// File: rtl/yutorina_timer_pkg.sv
// Shared definitions for the yutorina timer: bus widths, register map and
// the bit positions of the CTRL and INTR fields.
package yutorina_timer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 2;

    localparam int unsigned CTRL_START_BIT    = 0;
    localparam int unsigned CTRL_PERIODIC_BIT = 1;
    localparam int unsigned INTR_FLAG_BIT     = 0;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [ADDR_W-1:0] {
        REG_CTRL    = 2'd0,
        REG_INTR    = 2'd1,
        REG_EXPR    = 2'd2,
        REG_COUNTER = 2'd3
    } reg_idx_e;

endpackage

// File: rtl/yutorina_timer.sv
// Free-running 32-bit timer with an expiry compare, one-shot/periodic modes and
// a level interrupt, behind a simple active-low strobe bus with one-cycle acknowledge.
module yutorina_timer
    import yutorina_timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] w_data,
    output logic [WORD_W-1:0] r_data,
    output logic              rdy_,
    output logic              irq
);

    logic              r_start;
    logic              r_periodic;
    logic              r_flag;
    logic [WORD_W-1:0] r_expr;
    logic [WORD_W-1:0] r_counter;

    logic              w_req;
    logic              w_rd;
    logic              w_wr_ctrl;
    logic              w_wr_intr;
    logic              w_wr_expr;
    logic              w_wr_counter;
    logic              w_expire;
    logic [WORD_W-1:0] w_rd_mux;

    // Bus request decode
    always_comb begin
        w_req        = !cs_ && !as_;
        w_rd         = w_req && (rw == RW_READ);
        w_wr_ctrl    = 1'b0;
        w_wr_intr    = 1'b0;
        w_wr_expr    = 1'b0;
        w_wr_counter = 1'b0;
        if (w_req && (rw == RW_WRITE)) begin
            case (reg_idx_e'(addr))
                REG_CTRL:    w_wr_ctrl    = 1'b1;
                REG_INTR:    w_wr_intr    = 1'b1;
                REG_EXPR:    w_wr_expr    = 1'b1;
                REG_COUNTER: w_wr_counter = 1'b1;
                default:     ;
            endcase
        end
    end

    assign w_expire = r_start && (r_counter == r_expr);

    // Read mux; unused CTRL/INTR bits read as zero
    always_comb begin
        w_rd_mux = '0;
        case (reg_idx_e'(addr))
            REG_CTRL: begin
                w_rd_mux[CTRL_START_BIT]    = r_start;
                w_rd_mux[CTRL_PERIODIC_BIT] = r_periodic;
            end
            REG_INTR:    w_rd_mux[INTR_FLAG_BIT] = r_flag;
            REG_EXPR:    w_rd_mux = r_expr;
            REG_COUNTER: w_rd_mux = r_counter;
            default:     w_rd_mux = '0;
        endcase
    end

    // Acknowledge and read data; data stays zero unless a read is acknowledged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_   <= 1'b1;
            r_data <= '0;
        end else begin
            rdy_   <= !w_req;
            r_data <= w_rd ? w_rd_mux : '0;
        end
    end

    // CTRL: a bus write overrides the one-shot self-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start    <= 1'b0;
            r_periodic <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_start    <= w_data[CTRL_START_BIT];
            r_periodic <= w_data[CTRL_PERIODIC_BIT];
        end else if (w_expire && !r_periodic) begin
            r_start    <= 1'b0;
        end
    end

    // INTR: expiry beats a same-cycle bus write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= 1'b0;
        end else if (w_expire) begin
            r_flag <= 1'b1;
        end else if (w_wr_intr) begin
            r_flag <= w_data[INTR_FLAG_BIT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expr <= '0;
        end else if (w_wr_expr) begin
            r_expr <= w_data;
        end
    end

    // COUNTER: bus write beats expiry reload, which beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_counter <= '0;
        end else if (w_wr_counter) begin
            r_counter <= w_data;
        end else if (w_expire) begin
            r_counter <= '0;
        end else if (r_start) begin
            r_counter <= r_counter + WORD_W'(1);
        end
    end

    assign irq = r_flag;

endmodule

// File: tb/tb_yutorina_timer.sv
// Directed and randomized bench for yutorina_timer against a register-level
// behavioural model of the timer rules.
module tb_yutorina_timer;

    logic        clk;
    logic        rst;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] w_data;
    logic [31:0] r_data;
    logic        rdy_;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_start, m_per, m_flag;
    logic [31:0] m_expr, m_cnt;
    logic        m_rdy;
    logic [31:0] m_rdata;

    yutorina_timer dut (
        .clk    (clk),
        .rst    (rst),
        .cs_    (cs_),
        .as_    (as_),
        .rw     (rw),
        .addr   (addr),
        .w_data (w_data),
        .r_data (r_data),
        .rdy_   (rdy_),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_start = 1'b0; m_per = 1'b0; m_flag = 1'b0;
        m_expr  = '0;   m_cnt = '0;
        m_rdy   = 1'b1; m_rdata = '0;
    endtask

    // One clock edge of the timer rules, using the inputs present at that edge
    task automatic model_step();
        logic req, expire;
        req     = !cs_ && !as_;
        m_rdy   = !req;
        m_rdata = '0;
        if (req && rw) begin
            case (addr)
                2'd0: m_rdata = {30'b0, m_per, m_start};
                2'd1: m_rdata = {31'b0, m_flag};
                2'd2: m_rdata = m_expr;
                default: m_rdata = m_cnt;
            endcase
        end
        expire = m_start && (m_cnt == m_expr);
        if (expire) begin
            m_cnt  = '0;
            m_flag = 1'b1;
            if (!m_per) m_start = 1'b0;
        end else if (m_start) begin
            m_cnt = m_cnt + 32'd1;
        end
        if (req && !rw) begin
            case (addr)
                2'd0: {m_per, m_start} = w_data[1:0];
                2'd1: if (!expire) m_flag = w_data[0];
                2'd2: m_expr = w_data;
                default: m_cnt = w_data;
            endcase
        end
    endtask

    task automatic cycle(input logic c, input logic a, input logic r,
                         input logic [1:0] ad, input logic [31:0] d);
        cs_ = c; as_ = a; rw = r; addr = ad; w_data = d;
        @(posedge clk);
        model_step();
        #1;
        check("rdy_", 32'(rdy_), 32'(m_rdy));
        check("r_data", r_data, m_rdata);
        check("irq", 32'(irq), 32'(m_flag));
    endtask

    task automatic wr(input logic [1:0] ad, input logic [31:0] d);
        cycle(1'b0, 1'b0, 1'b0, ad, d);
    endtask

    task automatic rd(input logic [1:0] ad);
        cycle(1'b0, 1'b0, 1'b1, ad, 32'd0);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b1, 1'b1, 2'd0, 32'd0);
    endtask

    initial begin
        int n;
        int rises;
        logic prev;
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = 2'd0; w_data = '0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 32'(rdy_), 32'd1);
        check("reset_rdata", r_data, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i));
            check("reset_reg", r_data, 32'd0);
        end

        // Periodic: EXPR=5 gives a 6-cycle period, COUNTER reads 0..5
        wr(2'd2, 32'd5);
        wr(2'd0, 32'd3);
        n = 0;
        while (!irq && n < 50) begin idle(); n++; end
        check("first_period", 32'(n), 32'd6);
        wr(2'd1, 32'd0);
        n = 1;
        while (!irq && n < 50) begin idle(); n++; end
        check("second_period", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            rd(2'd3);
            check("counter_seq", r_data, 32'(i));
        end
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd0);

        // One-shot: single interrupt, start self-clears, counter parks at 0
        wr(2'd3, 32'd0);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'd1);
        rises = 0;
        prev  = irq;
        repeat (20) begin
            idle();
            if (irq && !prev) rises++;
            prev = irq;
        end
        check("oneshot_rises", 32'(rises), 32'd1);
        rd(2'd0);
        check("oneshot_ctrl", r_data, 32'd0);
        rd(2'd3);
        check("oneshot_counter", r_data, 32'd0);

        // Back-to-back reads with as_ held low
        wr(2'd2, 32'h1234_5678);
        wr(2'd3, 32'h0000_00AB);
        wr(2'd0, 32'd2);
        rd(2'd0); check("b2b_ctrl", r_data, 32'd2);          check("b2b_rdy0", 32'(rdy_), 32'd0);
        rd(2'd1); check("b2b_intr", r_data, 32'd1);          check("b2b_rdy1", 32'(rdy_), 32'd0);
        rd(2'd2); check("b2b_expr", r_data, 32'h1234_5678);  check("b2b_rdy2", 32'(rdy_), 32'd0);
        rd(2'd3); check("b2b_cnt",  r_data, 32'h0000_00AB);  check("b2b_rdy3", 32'(rdy_), 32'd0);
        idle();
        check("b2b_idle_rdy", 32'(rdy_), 32'd1);
        check("b2b_idle_data", r_data, 32'd0);

        // Expiry beats a same-cycle INTR clear
        wr(2'd1, 32'd0);
        wr(2'd3, 32'd0);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd3);
        n = 0;
        while (!(m_start && m_cnt == m_expr) && n < 20) begin idle(); n++; end
        check("expiry_wait", 32'(n < 20), 32'd1);
        wr(2'd1, 32'd0);
        check("intr_clear_on_expiry", 32'(irq), 32'd1);
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd0);
        check("intr_clear_later", 32'(irq), 32'd0);

        // Unselected or unstrobed requests are ignored
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd3);
        check("nocs_rdy", 32'(rdy_), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'd99);
        check("noas_rdy", 32'(rdy_), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 2'd1, 32'd1);
        check("none_rdy", 32'(rdy_), 32'd1);
        rd(2'd0); check("ignored_ctrl", r_data, 32'd0);
        rd(2'd2); check("ignored_expr", r_data, 32'd2);
        rd(2'd1); check("ignored_intr", r_data, 32'd0);

        // Reset lands while a write acknowledge is pending
        wr(2'd2, 32'd7);
        rst = 1'b1;
        #1;
        check("midrst_rdy", 32'(rdy_), 32'd1);
        check("midrst_rdata", r_data, 32'd0);
        model_reset();
        cs_ = 1'b1; as_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("inrst_rdy", 32'(rdy_), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i));
            check("postrst_reg", r_data, 32'd0);
        end

        // Randomized traffic with small compare values so expiries collide with writes
        repeat (600) begin
            logic        c, a, r;
            logic [1:0]  ad;
            logic [31:0] d;
            if ($urandom_range(0, 4) != 0) begin c = 1'b0; a = 1'b0; end
            else begin c = 1'($urandom_range(0, 1)); a = ~c | 1'($urandom_range(0, 1)); end
            r  = 1'($urandom_range(0, 1));
            ad = 2'($urandom_range(0, 3));
            case (ad)
                2'd0: d = $urandom_range(0, 7) == 0 ? $urandom() : 32'($urandom_range(1, 3));
                2'd1: d = $urandom_range(0, 3) == 0 ? $urandom() : 32'($urandom_range(0, 1));
                2'd2: d = 32'($urandom_range(0, 6));
                default: d = $urandom_range(0, 9) == 0 ? 32'hFFFF_FFFE : 32'($urandom_range(0, 6));
            endcase
            cycle(c, a, r, ad, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
